led_chase_player: RTL

LED_CHASE_PLAYER -- requirements
Module: led_chase_player

---
 rtl/led_chase_player.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/led_chase_player.sv
// led_chase_player: plays one round of an LED chase game per accepted start.
// It latches a one-hot target LED, watches the chasing LEDs, presses stop for
// a fixed number of cycles once the target lights, then waits for the game's
// Result line and reports the outcome with a one-cycle done pulse.
//
// Handshake: start is a request sampled on every rising edge. It is accepted
// only in IDLE with a one-hot target, is rejected with a one-cycle error
// pulse in IDLE with a bad target, and is silently dropped whenever busy=1.
module led_chase_player #(
    parameter int PRESS_LEN      = 4,
    parameter int WATCH_TIMEOUT  = 64,
    parameter int RESULT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] target,
    input  logic       LED1,
    input  logic       LED2,
    input  logic       LED3,
    input  logic       LED4,
    input  logic       Result,
    output logic       stopButton,
    output logic [3:0] stopLED,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [7:0] win_count,
    output logic       error,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WATCH  = 3'd1,
        PRESS  = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } state_t;

    // One shared counter times every phase, so it must reach the largest limit.
    localparam int CNT_MAX_A = (WATCH_TIMEOUT > RESULT_TIMEOUT) ? WATCH_TIMEOUT : RESULT_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > PRESS_LEN) ? CNT_MAX_A : PRESS_LEN;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] WATCH_LAST  = CW'(WATCH_TIMEOUT - 1);
    localparam logic [CW-1:0] PRESS_LAST  = CW'(PRESS_LEN - 1);
    localparam logic [CW-1:0] RESULT_LAST = CW'(RESULT_TIMEOUT - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          seen;
    logic          seen_nx;
    logic          sb_nx;
    logic [3:0]    led_nx;
    logic          win_nx;
    logic [7:0]    wc_nx;
    logic          err_nx;
    logic [3:0]    leds;
    logic          target_ok;

    assign leds      = {LED4, LED3, LED2, LED1};
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign target_ok = (target != 4'b0000) && ((target & (target - 4'd1)) == 4'b0000);

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    // Next-state and next-register decisions for every phase of a round.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        seen_nx  = seen;
        sb_nx    = 1'b0;
        led_nx   = stopLED;
        win_nx   = win;
        wc_nx    = win_count;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (target_ok) begin
                        led_nx   = target;
                        cnt_nx   = '0;
                        state_nx = WATCH;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            WATCH: begin
                // A match wins over a timeout landing in the same cycle.
                if (leds == stopLED) begin
                    state_nx = PRESS;
                    sb_nx    = 1'b1;
                    cnt_nx   = '0;
                    seen_nx  = 1'b0;
                end else if (cnt == WATCH_LAST) begin
                    state_nx = DONE;
                    win_nx   = 1'b0;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PRESS: begin
                // A Result seen while still pressing is remembered as a win.
                seen_nx = seen | Result;
                if (cnt == PRESS_LAST) begin
                    state_nx = RESULT;
                    cnt_nx   = '0;
                end else begin
                    sb_nx  = 1'b1;
                    cnt_nx = cnt + 1'b1;
                end
            end
            RESULT: begin
                if (Result || seen) begin
                    state_nx = DONE;
                    win_nx   = 1'b1;
                    cnt_nx   = '0;
                    if (win_count != 8'hFF) begin
                        wc_nx = win_count + 8'd1;
                    end
                end else if (cnt == RESULT_LAST) begin
                    state_nx = DONE;
                    win_nx   = 1'b0;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath registers: phase counter, stop press, latched target, outcome.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            seen       <= 1'b0;
            stopButton <= 1'b0;
            stopLED    <= 4'b0000;
            win        <= 1'b0;
            win_count  <= 8'd0;
            error      <= 1'b0;
        end else begin
            cnt        <= cnt_nx;
            seen       <= seen_nx;
            stopButton <= sb_nx;
            stopLED    <= led_nx;
            win        <= win_nx;
            win_count  <= wc_nx;
            error      <= err_nx;
        end
    end

endmodule
